// File: rtl/ff_bank_arbiter.sv
// rtl/ff_bank_arbiter.sv - round-robin write arbiter and sequencer for a shared flip-flop bank
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   req       per-requester write request (level, held until ack)
//   din       write data, requester i on din[i*WIDTH +: WIDTH]
//   clr       bank clear request (level, held until clr_done)
//   ff_q      current bank output, fed back for recirculation
//   ff_d      bank d input
//   ff_rst    bank synchronous reset, active-high
//   gnt       one-hot grant, high in WRITE
//   ack       one-hot one-cycle pulse to the winner, in ACK
//   clr_done  one-cycle pulse in the IDLE cycle after CLEAR
//   busy      high in any state other than IDLE
module ff_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 14,
    parameter int IDX_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       ff_q,
    output logic [WIDTH-1:0]       ff_d,
    output logic                   ff_rst,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   clr_done,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              clr_done_q, clr_done_d;

    logic [WIDTH-1:0]  din_a [N_REQ];
    logic [IDX_W:0]    cand;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            din_a[i] = din[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin scan: first set req bit at or above ptr, wrapping at N_REQ.
    // One extra bit on cand keeps ptr+i from overflowing before the wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        data_d     = data_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Clear wins over writes; pending reqs are simply seen later.
                if (clr) begin
                    state_d = CLEAR;
                end else if (win_found) begin
                    idx_d   = win_idx;
                    data_d  = din_a[win_idx];
                    state_d = WRITE;
                end
            end
            WRITE: state_d = ACK;
            ACK: begin
                ptr_d   = (idx_q == IDX_W'(N_REQ-1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            CLEAR: begin
                clr_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign gnt      = (state_q == WRITE) ? (N_REQ'(1) << idx_q) : '0;
    assign ack      = (state_q == ACK)   ? (N_REQ'(1) << idx_q) : '0;
    assign busy     = (state_q != IDLE);
    assign clr_done = clr_done_q;

    // Recirculating q holds the bank without an enable pin.
    assign ff_d   = (state_q == WRITE) ? data_q : ff_q;
    // Bank is held cleared for every edge while rst is low.
    assign ff_rst = ~rst | (state_q == CLEAR);

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// tb/tb_ff_bank_arbiter.sv - self-checking bench for ff_bank_arbiter
module tb_ff_bank_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 14;
    localparam int IDX_W = 2;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] din;
    logic                   clr;
    logic [WIDTH-1:0]       ff_q;
    logic [WIDTH-1:0]       ff_d;
    logic                   ff_rst;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic                   clr_done;
    logic                   busy;

    ff_bank_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .clr(clr), .ff_q(ff_q),
        .ff_d(ff_d), .ff_rst(ff_rst), .gnt(gnt), .ack(ack),
        .clr_done(clr_done), .busy(busy)
    );

    // Flip-flop bank: synchronous active-high reset, no enable.
    logic [WIDTH-1:0] bank = 14'h2AAA;
    always @(posedge clk) bank <= ff_rst ? '0 : ff_d;
    assign ff_q = bank;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [N_REQ-1:0] ack;
        logic [WIDTH-1:0] data;
    } sb_t;

    typedef struct packed {
        logic [N_REQ-1:0] req;
        logic [2:0]       n;
        logic [15:0]      exp;
    } row_t;

    sb_t  sb[$];
    row_t rows [7];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_ack = -1;
    bit   spacing_en = 0;
    int   ack3_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_din(input int i, input logic [WIDTH-1:0] v);
        din[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic push_exp(input int i);
        sb_t e;
        e.ack  = N_REQ'(1) << i;
        e.data = din[i*WIDTH +: WIDTH];
        sb.push_back(e);
    endtask

    // Advance one clock, sample #1 later, and score any ack against the queue.
    // Requesters drop req on the cycle their ack is seen.
    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (ack != '0) begin
            if (ack[3]) ack3_cnt++;
            if (spacing_en && last_ack >= 0) chk("ack_spacing", cyc - last_ack, 3);
            last_ack = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_ack", {28'd0, ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_vec", {28'd0, ack}, {28'd0, e.ack});
                chk("ack_data", {18'd0, ff_q}, {18'd0, e.data});
            end
            req = req & ~ack;
        end
    endtask

    task automatic run_until_empty(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            chk("sb_drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Single write by requester i; returns in the IDLE cycle after ACK.
    task automatic run_one(input int i, input logic [WIDTH-1:0] v);
        set_din(i, v);
        push_exp(i);
        req = N_REQ'(1) << i;
        run_until_empty(10);
        step();
    endtask

    initial begin
        logic [N_REQ-1:0] e1;
        int w;

        rows[0] = {4'b1111, 3'd4, 16'h8421};
        rows[1] = {4'b1001, 3'd2, 16'h0081};
        rows[2] = {4'b0100, 3'd1, 16'h0004};
        rows[3] = {4'b0001, 3'd1, 16'h0001};
        rows[4] = {4'b1101, 3'd3, 16'h0184};
        rows[5] = {4'b0110, 3'd2, 16'h0042};
        rows[6] = {4'b1010, 3'd2, 16'h0028};

        // Reset state
        rst = 1'b0; req = '0; clr = 1'b0; din = '0;
        #1;
        chk("rst_ff_d_recirc", {18'd0, ff_d}, 32'h2AAA);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ff_rst", {31'd0, ff_rst}, 32'd1);
            chk("rst_gnt", {28'd0, gnt}, 32'd0);
            chk("rst_ack", {28'd0, ack}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            step();
        end
        chk("rst_bank_cleared", {18'd0, ff_q}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_ff_rst", {31'd0, ff_rst}, 32'd0);
        chk("rel_ff_d", {18'd0, ff_d}, 32'd0);
        chk("rel_clr_done", {31'd0, clr_done}, 32'd0);

        // Round-robin table: each row runs from the ptr left by the previous one
        spacing_en = 1;
        for (int r = 0; r < 7; r++) begin
            last_ack = -1;
            for (int i = 0; i < N_REQ; i++) set_din(i, WIDTH'($urandom_range(0, 16383)));
            for (int k = 0; k < int'(rows[r].n); k++) begin
                e1 = rows[r].exp[k*4 +: 4];
                w = 0;
                for (int i = 0; i < N_REQ; i++) if (e1[i]) w = i;
                push_exp(w);
            end
            req = rows[r].req;
            run_until_empty(40);
            chk("row_req_cleared", {28'd0, req}, 32'd0);
            step();
        end
        spacing_en = 0;

        // Single write, ptr=2
        set_din(2, 14'h1A5);
        push_exp(2);
        req = 4'b0100;
        step();
        chk("sw_gnt", {28'd0, gnt}, 32'h4);
        chk("sw_busy", {31'd0, busy}, 32'd1);
        chk("sw_ff_d", {18'd0, ff_d}, 32'h1A5);
        chk("sw_no_ack_in_write", {28'd0, ack}, 32'd0);
        step();
        chk("sw_ack", {28'd0, ack}, 32'h4);
        chk("sw_gnt_off", {28'd0, gnt}, 32'd0);
        step();
        chk("sw_idle_busy", {31'd0, busy}, 32'd0);
        chk("sw_ack_pulse", {28'd0, ack}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("sw_hold", {18'd0, ff_q}, 32'h1A5);
        end

        // Fill bank with all ones (ptr=3 -> requester 0 wins, ptr becomes 1)
        run_one(0, 14'h3FFF);
        chk("fill_ff_q", {18'd0, ff_q}, 32'h3FFF);

        // Clear has priority over a simultaneous request
        set_din(1, 14'h0123);
        push_exp(1);
        clr = 1'b1;
        req = 4'b0010;
        step();
        chk("clr_ff_rst", {31'd0, ff_rst}, 32'd1);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        chk("clr_gnt", {28'd0, gnt}, 32'd0);
        step();
        chk("clr_ff_q", {18'd0, ff_q}, 32'd0);
        chk("clr_done", {31'd0, clr_done}, 32'd1);
        chk("clr_idle", {31'd0, busy}, 32'd0);
        clr = 1'b0;
        step();
        chk("clr_then_gnt", {28'd0, gnt}, 32'h2);
        chk("clr_done_pulse", {31'd0, clr_done}, 32'd0);
        step();
        chk("clr_then_ack", {28'd0, ack}, 32'h2);
        chk("clr_sb_empty", sb.size(), 0);
        step();

        // One-cycle req pulse still completes with latched data (ptr=2)
        ack3_cnt = 0;
        set_din(3, 14'h2222);
        push_exp(3);
        req = 4'b1000;
        step();
        req = '0;
        set_din(3, 14'h1111);
        for (int k = 0; k < 6; k++) step();
        chk("drop_ack3_once", ack3_cnt, 1);
        chk("drop_sb_empty", sb.size(), 0);

        // Reset during WRITE aborts the transaction and resets ptr
        run_one(0, 14'h0555);
        set_din(2, 14'h0777);
        req = 4'b0100;
        step();
        chk("mr_gnt", {28'd0, gnt}, 32'h4);
        rst = 1'b0;
        #1;
        chk("mr_ack", {28'd0, ack}, 32'd0);
        chk("mr_gnt_off", {28'd0, gnt}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_ff_rst", {31'd0, ff_rst}, 32'd1);
        req = '0;
        step();
        chk("mr_ff_q", {18'd0, ff_q}, 32'd0);
        chk("mr_no_ack", {28'd0, ack}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mr_rel_ff_rst", {31'd0, ff_rst}, 32'd0);
        chk("mr_rel_busy", {31'd0, busy}, 32'd0);
        set_din(0, 14'h0A0A);
        set_din(3, 14'h0B0B);
        push_exp(0);
        push_exp(3);
        req = 4'b1001;
        run_until_empty(20);
        step();
        chk("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ff_bank_arbiter.md
# ff_bank_arbiter

Round-robin write arbiter and sequencer for a shared WIDTH-bit bank of synchronous-reset D flip-flops.
- Up to N_REQ requesters compete to load the bank; a separate clear request resets it.
- The block owns the bank's d input and reset input. It recirculates q when idle, so the bank holds its value without an enable pin.
- It sits between the requesting FSMs and the flip-flop bank; the bank's q is fed back to this block and to the consumers.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 14, bank data width
- IDX_W, 2, index width; must equal ceil(log2(N_REQ))
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset: one clock; reset is asynchronous and active-low
- req  in  N_REQ  per-requester write request, level, held until ack
- din  in  N_REQ*WIDTH  write data, requester i on bits [i*WIDTH +: WIDTH]
- clr  in  1  bank clear request, level, held until clr_done
- ff_q  in  WIDTH  current bank output
- ff_d  out  WIDTH  bank d input
- ff_rst  out  1  bank synchronous reset, active-high
- gnt  out  N_REQ  one-hot grant, high during the WRITE state
- ack  out  N_REQ  one-cycle pulse to the winner, in the ACK state
- clr_done  out  1  one-cycle pulse after a clear
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WRITE, ACK, CLEAR.
- IDLE:
  - If clr=1, go to CLEAR. clr has priority over req; pending reqs stay pending.
  - Otherwise, if any req bit is set, pick a winner by round-robin: the first set bit searching upward from ptr, wrapping from N_REQ-1 to 0.
  - Latch the winner index into idx_r and its din slice into data_r, then go to WRITE.
  - Otherwise stay in IDLE.
- WRITE: gnt[idx_r]=1, ff_d=data_r. Unconditionally go to ACK.
- ACK: ack[idx_r]=1, ptr <= (idx_r+1) mod N_REQ. Go to IDLE.
- CLEAR: ff_rst=1. Next state IDLE, with clr_done=1 for one cycle in that IDLE cycle (registered pulse).
- ff_d equals ff_q in every state except WRITE. The bank therefore holds its value.
- ff_rst = (~rst) | (state==CLEAR). The bank is cleared on every clock edge while rst is low.
- Once a transaction is latched it completes, even if its req drops in WRITE or ACK. data_r is used, not live din.
- A requester must not see a second ack unless it still holds req in IDLE after its ack. Requesters drop req on the cycle ack is seen; if req is still high in the next IDLE, it is treated as a new request.
- ptr does not change on a clear.
- Reset values (async, while rst=0):
  - state=IDLE, ptr=0, idx_r=0, data_r=0
  - gnt=0, ack=0, clr_done=0, busy=0
  - ff_rst=1, ff_d=ff_q
- Reset mid-transaction aborts it: no ack is issued, and the bank is cleared by ff_rst.

## Timing
- Write latency:
  - req sampled at edge E0 in IDLE.
  - WRITE occupies cycle E0..E1; the bank captures data_r at E1.
  - ACK occupies E1..E2 and ff_q already shows the new value.
  - Back in IDLE at E2.
- Throughput: one write per 3 cycles with continuous requests; the IDLE arbitration cycle is included.
- Clear latency:
  - clr sampled at E0; CLEAR occupies E0..E1.
  - ff_q=0 after E1; clr_done is high during E1..E2.
  - Throughput is 2 cycles per clear.
- gnt, ack and busy decode from the state register (glitch-free); ff_d and ff_rst are combinational muxes.
- Fairness bound: a requester holding req waits at most N_REQ-1 other grants, plus any interleaved clears.
- Wrap-around: with ptr=N_REQ-1 and only req[0] set, the winner is 0 and ptr becomes 1.

## Test plan
- Reset check:
  - Stimulus: rst=0 for 3 cycles with ff_q driven nonzero.
  - Required: ff_rst=1, gnt=0, ack=0, busy=0 throughout; after release, ff_rst=0 and ff_d=ff_q.
- Single write:
  - Stimulus: req=4'b0100, din slice 2 = 14'h1A5.
  - Required: gnt=4'b0100 in WRITE; ff_q=14'h1A5 after E1; ack=4'b0100 for one cycle in ACK; ff_q holds 14'h1A5 for 5 further idle cycles.
- Round-robin:
  - Stimulus: req=4'b1111 held, each requester dropping its req on its ack.
  - Required: grants in order 0,1,2,3, each 3 cycles apart.
  - Then ptr=0; reassert req=4'b1001 → grant 0 then 3.
- Clear priority:
  - Stimulus: clr=1 and req=4'b0010 asserted in the same IDLE cycle, with ff_q=14'h3FFF.
  - Required: CLEAR first, ff_q=0, clr_done pulse; then write for requester 1, acked 2 cycles after IDLE.
- Request drop:
  - Stimulus: req[3] pulsed for one cycle in IDLE.
  - Required: the transaction still completes, with ack[3] pulsed once.
- Reset mid-write:
  - Stimulus: rst=0 asserted during WRITE.
  - Required: no ack; ff_q=0 at the next edge; after release the block is in IDLE with ptr=0.
